// File: rtl/tmw_seq_pkg.sv
// Shared types and constants for the TMW window sequencer.
package tmw_seq_pkg;

    localparam int unsigned DEF_N          = 5;
    localparam int unsigned DEF_W          = 8;
    localparam int unsigned DEF_G          = 4;
    localparam int unsigned MIN_MAX_COUNTS = 1;

    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_LOAD   = 6'b000010,
        ST_ARM    = 6'b000100,
        ST_COUNT  = 6'b001000,
        ST_OUTPUT = 6'b010000,
        ST_GAP    = 6'b100000
    } state_t;

endpackage

// File: rtl/tmw_window_sequencer_if.sv
// TMW counter control/readback and captured-sample valid/ready port.
interface tmw_window_sequencer_if #(
    parameter int unsigned N = tmw_seq_pkg::DEF_N
);
    logic         tmw_valid;
    logic [N-1:0] tmw_max_counts;
    logic         tmw_en;
    logic [N-1:0] tmw_data;
    logic         sample_valid;
    logic [N-1:0] sample_data;
    logic         sample_ready;

    modport master (
        output tmw_valid, tmw_max_counts, sample_valid, sample_data,
        input  tmw_en, tmw_data, sample_ready
    );

    modport slave (
        input  tmw_valid, tmw_max_counts, sample_valid, sample_data,
        output tmw_en, tmw_data, sample_ready
    );
endinterface

// File: rtl/tmw_seq_timer.sv
// Loadable down-counter with zero flag; shared by the inter-window gap and the watchdog.
module tmw_seq_timer #(
    parameter int unsigned TW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);
    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/tmw_window_sequencer.sv
// Sequencer for the TRNG TMW counter: loads, arms and times windows, captures counts
// and streams them out. Define TMW_SEQ_WATCHDOG_EN to add ARM/COUNT timeouts and err.
module tmw_window_sequencer
    import tmw_seq_pkg::*;
#(
    parameter int unsigned N         = DEF_N,
    parameter int unsigned W         = DEF_W,
    parameter int unsigned G         = DEF_G,
    parameter int unsigned TO_MARGIN = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          stop,
    input  logic [N-1:0]                  cfg_max_counts,
    input  logic [W-1:0]                  cfg_num_windows,
    input  logic [G-1:0]                  cfg_gap,
    tmw_window_sequencer_if.master        bus,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);
    // Wide enough for max_counts + TO_MARGIN as well as the gap length.
    localparam int unsigned TW = ((N > G) ? N : G) + $clog2(TO_MARGIN + 1) + 1;

    state_t        state;
    logic [W-1:0]  num_q;
    logic [W-1:0]  win_cnt;
    logic [G-1:0]  gap_q;
    logic          stop_pending;
    logic          stop_req;
    logic          last_win;
    logic          tmr_load;
    logic          tmr_dec;
    logic          tmr_zero;
    logic [TW-1:0] tmr_val;

    assign stop_req = stop_pending || stop;
    assign last_win = (num_q != '0) && ((win_cnt + 1'b1) == num_q);

    always_comb begin
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_OUTPUT: begin
                if (bus.sample_ready && (gap_q != '0)) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(gap_q) - TW'(1);
                end
            end
            ST_GAP: tmr_dec = 1'b1;
`ifdef TMW_SEQ_WATCHDOG_EN
            ST_LOAD: begin
                tmr_load = 1'b1;
                tmr_val  = TW'(TO_MARGIN - 1);
            end
            ST_ARM: begin
                if (bus.tmw_en) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(bus.tmw_max_counts) + TW'(TO_MARGIN - 1);
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_COUNT: tmr_dec = 1'b1;
`endif
            default: ;
        endcase
    end

    tmw_seq_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            num_q              <= '0;
            win_cnt            <= '0;
            gap_q              <= '0;
            stop_pending       <= 1'b0;
            bus.tmw_valid      <= 1'b0;
            bus.tmw_max_counts <= '0;
            bus.sample_valid   <= 1'b0;
            bus.sample_data    <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
`ifdef TMW_SEQ_WATCHDOG_EN
            err                <= 1'b0;
`endif
        end else begin
            bus.tmw_valid <= 1'b0;
            done          <= 1'b0;
            if ((state != ST_IDLE) && stop)
                stop_pending <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bus.tmw_max_counts <= (cfg_max_counts == '0) ? N'(MIN_MAX_COUNTS)
                                                                     : cfg_max_counts;
                        num_q         <= cfg_num_windows;
                        gap_q         <= cfg_gap;
                        win_cnt       <= '0;
                        stop_pending  <= 1'b0;
                        bus.tmw_valid <= 1'b1;
                        busy          <= 1'b1;
                        state         <= ST_LOAD;
`ifdef TMW_SEQ_WATCHDOG_EN
                        err           <= 1'b0;
`endif
                    end
                end
                ST_LOAD: state <= ST_ARM;
                ST_ARM: begin
                    if (bus.tmw_en) begin
                        state <= ST_COUNT;
                    end
`ifdef TMW_SEQ_WATCHDOG_EN
                    else if (tmr_zero) begin
                        err                <= 1'b1;
                        done               <= 1'b1;
                        busy               <= 1'b0;
                        stop_pending       <= 1'b0;
                        bus.tmw_max_counts <= '0;
                        state              <= ST_IDLE;
                    end
`endif
                end
                ST_COUNT: begin
                    if (!bus.tmw_en) begin
                        bus.sample_data  <= bus.tmw_data;
                        bus.sample_valid <= 1'b1;
                        state            <= ST_OUTPUT;
                    end
`ifdef TMW_SEQ_WATCHDOG_EN
                    else if (tmr_zero) begin
                        err                <= 1'b1;
                        done               <= 1'b1;
                        busy               <= 1'b0;
                        stop_pending       <= 1'b0;
                        bus.tmw_max_counts <= '0;
                        state              <= ST_IDLE;
                    end
`endif
                end
                ST_OUTPUT: begin
                    if (bus.sample_ready) begin
                        bus.sample_valid <= 1'b0;
                        win_cnt          <= win_cnt + 1'b1;
                        if (stop_req || last_win) begin
                            done               <= 1'b1;
                            busy               <= 1'b0;
                            stop_pending       <= 1'b0;
                            bus.tmw_max_counts <= '0;
                            state              <= ST_IDLE;
                        end else if (gap_q != '0) begin
                            state <= ST_GAP;
                        end else begin
                            bus.tmw_valid <= 1'b1;
                            state         <= ST_LOAD;
                        end
                    end
                end
                ST_GAP: begin
                    // A stop during the gap ends the run without opening another window.
                    if (stop_req) begin
                        done               <= 1'b1;
                        busy               <= 1'b0;
                        stop_pending       <= 1'b0;
                        bus.tmw_max_counts <= '0;
                        state              <= ST_IDLE;
                    end else if (tmr_zero) begin
                        bus.tmw_valid <= 1'b1;
                        state         <= ST_LOAD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef TMW_SEQ_WATCHDOG_EN
    assign err = 1'b0;
`endif

endmodule

// File: doc/tmw_window_sequencer.md
Name: tmw_window_sequencer

Overview:
Control-side sequencer for the TRNG time-measurement-window (TMW) counter. It programs the window length, issues the one-cycle start pulse, tracks the counter's enable, and captures the final count. It runs a programmed number of windows, or runs continuously, with an optional idle gap between windows. Captured counts go out on a valid/ready sample port toward the post-processing/entropy-extraction stage.

Parameters:
N, 5, width of max_counts/count data (matches the TMW counter width)
W, 8, width of cfg_num_windows
G, 4, width of cfg_gap (inter-window idle cycles)
TO_MARGIN, 4, watchdog slack cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
start  in  1  pulse; begin a run (accepted only in IDLE)
stop  in  1  pulse; request graceful end of the run
cfg_max_counts  in  N  window length; sampled at accepted start
cfg_num_windows  in  W  windows per run; 0 = continuous until stop
cfg_gap  in  G  idle cycles between windows; 0 = back-to-back
tmw_valid  out  1  one-cycle load/start pulse to the TMW counter
tmw_max_counts  out  N  window length to the TMW counter
tmw_en  in  1  TMW counter enable (window active)
tmw_data  in  N  TMW counter value
sample_valid  out  1  captured count available
sample_data  out  N  captured count
sample_ready  in  1  downstream accept
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a run ends (normal, stop or error)
err  out  1  sticky watchdog error

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. All outputs 0: tmw_valid, tmw_max_counts, sample_valid, sample_data, busy, done, err. A pending stop and the window count are also cleared. Reset mid-run aborts with no done pulse.
- States: IDLE, LOAD, ARM, COUNT, OUTPUT, GAP.
- IDLE: on start, latch cfg_* into shadow registers and go to LOAD. start outside IDLE is ignored. cfg_* changes after start have no effect until the next run.
- Max-counts rule: a latched cfg_max_counts of 0 is driven as 1. tmw_max_counts holds the latched value from LOAD until the run ends.
- LOAD: tmw_valid=1 for exactly this one cycle, then go to ARM.
- ARM: wait for tmw_en=1, then go to COUNT. The nominal wait is 1 cycle.
- COUNT: wait for tmw_en=0. On the first cycle tmw_en is sampled 0, capture tmw_data into sample_data and go to OUTPUT. sample_valid rises on the next edge.
- OUTPUT: hold sample_valid=1 and keep sample_data stable until sample_ready=1. A transfer occurs when valid&&ready; the window counter increments on that transfer.
  - Backpressure stalls the sequencer; no new window starts while a sample is pending.
  - If sample_ready is already high on the cycle sample_valid rises, the transfer completes in one cycle.
- After a transfer, the run ends if stop is pending or the window count reaches cfg_num_windows (when nonzero). Ending means: go to IDLE, done=1 for one cycle, busy falls on the same edge.
- Otherwise, go to GAP when cfg_gap>0, or directly to LOAD when cfg_gap=0.
- GAP: count cfg_gap cycles, then go to LOAD.
- stop: sets stop_pending in any non-IDLE state. The current window always completes and its sample is always delivered. A stop in GAP ends the run immediately (done pulse, no new window). stop in IDLE is ignored. start and stop in the same IDLE cycle: start wins and stop is dropped.
- Continuous mode (cfg_num_windows=0): the window counter wraps freely; only stop ends the run.

Optional Feature:
Macro TMW_SEQ_WATCHDOG_EN.
- With it:
  - ARM timeout: if tmw_en is not seen within TO_MARGIN cycles, set err.
  - COUNT timeout: if tmw_en stays high longer than latched max_counts+TO_MARGIN cycles, set err.
  - On either timeout: drop the current window (no sample), go to IDLE, pulse done.
  - err stays set until reset or the next accepted start.
- Without it: err is tied 0, there are no timers, and ARM/COUNT wait indefinitely.

Decomposition:
- Package tmw_seq_pkg holds:
  - the state enumeration and its encoding (one-hot, 6 bits);
  - the default widths N, W, G;
  - the MIN_MAX_COUNTS=1 constant.
- One sub-module, tmw_seq_timer: a loadable down-counter with a zero flag, shared by GAP and the watchdog. The two never run concurrently.

Test Plan:
- Single window: M=3, windows=1, gap=0, ready=1, TMW model asserts en for M+1 cycles and holds data=3 → exactly one tmw_valid pulse, sample_data=3, sample_valid high 1 cycle, done pulse, busy low.
- Multi-window with gap: M=2, windows=4, gap=5 → 4 samples; at least 5 idle cycles between sample transfer and the next tmw_valid; done pulses once after the 4th transfer.
- Backpressure: hold ready=0 for 10 cycles → sample_valid and sample_data stable for all 10 cycles, no tmw_valid issued, single transfer on release.
- Continuous + stop: windows=0, stop asserted mid-COUNT → current sample delivered, then IDLE with done, and no further tmw_valid; a second case with stop asserted in GAP → immediate done.
- Boundaries: cfg_max_counts=0 → tmw_max_counts=1; start while busy ignored; rst_n low mid-COUNT → all outputs 0 on the next edge, no done pulse.
- With TMW_SEQ_WATCHDOG_EN: tmw_en stuck 0 → err=1 after TO_MARGIN cycles in ARM, done pulse, no sample; next start clears err.
